// File: rtl/tx_dma_mwr_tlp_gen_pkg.sv
// Shared types for the DMA Memory-Write TLP generator: Avalon-ST sideband struct,
// MWr header layout and the header builder.
package tx_dma_mwr_tlp_gen_pkg;

    typedef struct packed {
        logic        valid;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic        err;
        logic [31:0] parity;
    } tx_st_avalon_type;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HDR,
        S_DATA,
        S_DONE
    } mwr_state_t;

    localparam logic [2:0] MWR_FMT_3DW = 3'b010;
    localparam logic [2:0] MWR_FMT_4DW = 3'b011;
    localparam logic [4:0] MWR_TYPE    = 5'b00000;

    // dw0 lands in bits [31:0] when the struct is placed on the bus
    typedef struct packed {
        logic [31:0] dw3;
        logic [31:0] dw2;
        logic [31:0] dw1;
        logic [31:0] dw0;
    } mwr_hdr_t;

    // 4DW form only when the address needs the upper 32 bits
    function automatic mwr_hdr_t build_mwr_hdr(input logic [63:0] addr,
                                               input logic [9:0]  len,
                                               input logic [15:0] req_id);
        mwr_hdr_t h;
        logic     is_4dw;
        is_4dw = |addr[63:32];
        h.dw0  = {(is_4dw ? MWR_FMT_4DW : MWR_FMT_3DW), MWR_TYPE, 1'b0, 3'b000,
                  4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
        h.dw1  = {req_id, 8'h00, 4'hF, 4'hF};
        if (is_4dw) begin
            h.dw2 = addr[63:32];
            h.dw3 = {addr[31:2], 2'b00};
        end else begin
            h.dw2 = {addr[31:2], 2'b00};
            h.dw3 = 32'd0;
        end
        return h;
    endfunction

endpackage

// File: rtl/tx_dma_mwr_tlp_gen_if.sv
// Descriptor, payload-buffer, arbiter and Avalon-ST signals of one TX DMA requester port.
interface tx_dma_mwr_tlp_gen_if #(
    parameter int PORT_WIDTH = 4
);
    import tx_dma_mwr_tlp_gen_pkg::*;

    logic                  iBLK_VALID;
    logic                  oBLK_READY;
    logic [63:0]           iBLK_ADDR;
    logic [PORT_WIDTH-1:0] iBLK_LINK;
    logic                  oDATA_RD;
    logic [6:0]            oDATA_RADDR;
    logic [255:0]          iDATA_RDATA;
    logic                  oREQ;
    logic                  iGNT;
    tx_st_avalon_type      oTX_ST;
    logic [255:0]          oTX_ST_DATA;
    logic [PORT_WIDTH-1:0] oLINK_NUMBER;
    logic                  oBLK_DONE_PULSE;

    modport master (
        input  iBLK_VALID, iBLK_ADDR, iBLK_LINK, iDATA_RDATA, iGNT,
        output oBLK_READY, oDATA_RD, oDATA_RADDR, oREQ, oTX_ST, oTX_ST_DATA,
               oLINK_NUMBER, oBLK_DONE_PULSE
    );

    modport slave (
        output iBLK_VALID, iBLK_ADDR, iBLK_LINK, iDATA_RDATA, iGNT,
        input  oBLK_READY, oDATA_RD, oDATA_RADDR, oREQ, oTX_ST, oTX_ST_DATA,
               oLINK_NUMBER, oBLK_DONE_PULSE
    );

endinterface

// File: rtl/tx_dma_mwr_tlp_gen.sv
// Splits one DMA block into back-to-back MWr TLPs while holding the arbiter request.
// Optional block/wait counters are built when TX_DMA_MWR_STATS_EN is defined.
module tx_dma_mwr_tlp_gen
    import tx_dma_mwr_tlp_gen_pkg::*;
#(
    parameter int          PORTS         = 12,
    parameter int          PORT_WIDTH    = $clog2(PORTS),
    parameter logic [15:0] REQ_ID        = 16'h0000,
    parameter int          PAYLOAD_BYTES = 128,
    parameter int          BLK_BYTES     = 4096
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    tx_dma_mwr_tlp_gen_if.master   bus,
    output logic [31:0]            oBLK_CNT,
    output logic [31:0]            oWAIT_CNT
);

    localparam int BEATS  = PAYLOAD_BYTES / 32;
    localparam int TLPS   = BLK_BYTES / PAYLOAD_BYTES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TLP_W  = (TLPS > 1) ? $clog2(TLPS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [TLP_W-1:0]  LAST_TLP  = TLP_W'(TLPS - 1);
    localparam logic [9:0]        LEN_DW    = 10'(PAYLOAD_BYTES / 4);
    localparam logic [63:0]       ADDR_MASK = ~64'(PAYLOAD_BYTES - 1);

    mwr_state_t            r_state;
    logic                  r_req;
    logic                  r_valid;
    logic                  r_sop;
    logic                  r_eop;
    logic                  r_done;
    logic [BEAT_W-1:0]     r_beat;
    logic [TLP_W-1:0]      r_tlp;
    logic [6:0]            r_raddr;
    logic [63:0]           r_addr;
    logic [PORT_WIDTH-1:0] r_link;

    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_last_tlp;
    logic                  w_tlp_adv;
    logic                  w_rd;
    logic [BEAT_W-1:0]     w_next_beat;
    logic                  w_enter_eop;
    mwr_hdr_t              w_hdr;

    always_comb begin
        w_accept    = (r_state == S_IDLE) && bus.iBLK_VALID;
        w_last_beat = (r_beat == LAST_BEAT);
        w_last_tlp  = (r_tlp == LAST_TLP);
        w_tlp_adv   = (r_state == S_DATA) && w_last_beat && !w_last_tlp;
        // Read one cycle ahead of every data beat: during HDR and all non-final data beats
        w_rd        = (r_state == S_HDR) || ((r_state == S_DATA) && !w_last_beat);
        w_next_beat = (r_state == S_HDR) ? '0 : r_beat + 1'b1;
        w_enter_eop = w_rd && (w_next_beat == LAST_BEAT);
        w_hdr       = build_mwr_hdr(r_addr, LEN_DW, REQ_ID);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_done  <= 1'b0;
            r_beat  <= '0;
            r_tlp   <= '0;
            r_raddr <= '0;
        end else begin
            if (w_rd)
                r_raddr <= r_raddr + 7'd1;
            case (r_state)
                S_IDLE: begin
                    if (bus.iBLK_VALID) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_tlp   <= '0;
                        r_raddr <= '0;
                    end
                end
                S_REQ: begin
                    if (bus.iGNT) begin
                        r_state <= S_HDR;
                        r_valid <= 1'b1;
                        r_sop   <= 1'b1;
                        r_eop   <= 1'b0;
                    end
                end
                S_HDR, S_DATA: begin
                    if ((r_state == S_DATA) && w_last_beat) begin
                        r_eop  <= 1'b0;
                        r_done <= 1'b0;
                        if (w_last_tlp) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                        end else begin
                            r_state <= S_HDR;
                            r_sop   <= 1'b1;
                            r_tlp   <= r_tlp + 1'b1;
                        end
                    end else begin
                        r_state <= S_DATA;
                        r_sop   <= 1'b0;
                        r_beat  <= w_next_beat;
                        r_eop   <= w_enter_eop;
                        // Drop the request together with the final beat so the
                        // arbiter can release the grant while it is written
                        if (w_enter_eop && w_last_tlp) begin
                            r_done <= 1'b1;
                            r_req  <= 1'b0;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Address and link are datapath only; they are always loaded before use
    always_ff @(posedge iCLK) begin
        if (w_accept) begin
            r_addr <= bus.iBLK_ADDR & ADDR_MASK;
            r_link <= bus.iBLK_LINK;
        end else if (w_tlp_adv) begin
            r_addr <= r_addr + 64'(PAYLOAD_BYTES);
        end
    end

    assign bus.oBLK_READY      = (r_state == S_IDLE);
    assign bus.oREQ            = r_req;
    assign bus.oDATA_RD        = w_rd;
    assign bus.oDATA_RADDR     = r_raddr;
    assign bus.oLINK_NUMBER    = r_link;
    assign bus.oBLK_DONE_PULSE = r_done;
    assign bus.oTX_ST          = '{valid: r_valid, sop: r_sop, eop: r_eop,
                                   empty: 2'b00, err: 1'b0, parity: 32'd0};
    assign bus.oTX_ST_DATA     = (r_state == S_HDR)  ? {128'd0, w_hdr} :
                                 (r_state == S_DATA) ? bus.iDATA_RDATA : 256'd0;

`ifdef TX_DMA_MWR_STATS_EN
    logic [31:0] r_blk_cnt;
    logic [31:0] r_wait_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_blk_cnt  <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (r_done)
                r_blk_cnt <= sat_inc(r_blk_cnt);
            if ((r_state == S_REQ) && !bus.iGNT)
                r_wait_cnt <= sat_inc(r_wait_cnt);
        end
    end

    assign oBLK_CNT  = r_blk_cnt;
    assign oWAIT_CNT = r_wait_cnt;
`else
    assign oBLK_CNT  = 32'd0;
    assign oWAIT_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_tx_dma_mwr_tlp_gen.sv
// Scoreboard bench for tx_dma_mwr_tlp_gen: expected beats queued per descriptor, popped per valid beat.
module tb_tx_dma_mwr_tlp_gen;
    import tx_dma_mwr_tlp_gen_pkg::*;

    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] blk_cnt;
    logic [31:0] wait_cnt;

    always #5 clk = ~clk;

    tx_dma_mwr_tlp_gen_if #(.PORT_WIDTH(PW)) bus ();

    tx_dma_mwr_tlp_gen #(.PORTS(12)) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .bus       (bus),
        .oBLK_CNT  (blk_cnt),
        .oWAIT_CNT (wait_cnt)
    );

    typedef struct {
        logic [255:0]  data;
        logic          sop;
        logic          eop;
        logic          done;
        logic          req;
        logic [PW-1:0] link;
    } beat_t;

    beat_t    sbq[$];
    int       n_chk = 0;
    int       n_err = 0;
    int       beat_cnt = 0;
    int       rd_cnt = 0;
    int       low_cnt = 0;
    bit       gap_pend = 0;
    logic [6:0] exp_raddr = '0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] word(input logic [PW-1:0] link, input logic [6:0] idx);
        logic [255:0] w;
        for (int j = 0; j < 8; j++)
            w[j*32 +: 32] = {4'h0, link, 8'(j), 9'd0, idx};
        return w;
    endfunction

    function automatic logic [255:0] exp_hdr(input logic [63:0] a);
        logic [31:0] d0, d1, d2, d3;
        logic        four;
        four = (a[63:32] != 32'd0);
        d0   = {(four ? 3'b011 : 3'b010), 19'd0, 10'd32};
        d1   = {16'h0000, 8'h00, 8'hFF};
        if (four) begin
            d2 = a[63:32];
            d3 = {a[31:2], 2'b00};
        end else begin
            d2 = {a[31:2], 2'b00};
            d3 = 32'd0;
        end
        return {128'd0, d3, d2, d1, d0};
    endfunction

    // Payload buffer: registered read, data one cycle after the strobe
    always @(posedge clk)
        if (bus.oDATA_RD)
            bus.iDATA_RDATA <= word(bus.oLINK_NUMBER, bus.oDATA_RADDR);

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (bus.oDATA_RD) begin
                chk("raddr", 256'(bus.oDATA_RADDR), 256'(exp_raddr));
                exp_raddr = exp_raddr + 7'd1;
                rd_cnt++;
            end
            if (bus.oTX_ST.valid) begin
                beat_cnt++;
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 256'(1), 256'(0));
                end else begin
                    e = sbq.pop_front();
                    chk("data", bus.oTX_ST_DATA, e.data);
                    chk("sop",  256'(bus.oTX_ST.sop), 256'(e.sop));
                    chk("eop",  256'(bus.oTX_ST.eop), 256'(e.eop));
                    chk("done", 256'(bus.oBLK_DONE_PULSE), 256'(e.done));
                    chk("req",  256'(bus.oREQ), 256'(e.req));
                    chk("fixed_fields", 256'({bus.oTX_ST.empty, bus.oTX_ST.err, bus.oTX_ST.parity}), 256'(0));
                    if (e.sop && gap_pend) begin
                        chk("req_gap", 256'(low_cnt >= 1), 256'(1));
                        gap_pend = 0;
                    end
                    if (e.done) begin
                        chk("link", 256'(bus.oLINK_NUMBER), 256'(e.link));
                        chk("rd_count", 256'(rd_cnt), 256'(128));
                        rd_cnt   = 0;
                        gap_pend = 1;
                        low_cnt  = 0;
                    end
                end
            end else begin
                chk("idle_done", 256'(bus.oBLK_DONE_PULSE), 256'(0));
                if (gap_pend && !bus.oREQ)
                    low_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_blk(input logic [63:0] addr, input logic [PW-1:0] link);
        logic [63:0] a;
        int          w;
        bit          last;
        a = {addr[63:7], 7'd0};
        for (int t = 0; t < 32; t++) begin
            sbq.push_back('{exp_hdr(a), 1'b1, 1'b0, 1'b0, 1'b1, link});
            for (int b = 0; b < 4; b++) begin
                w    = t * 4 + b;
                last = (t == 31) && (b == 3);
                sbq.push_back('{word(link, 7'(w)), 1'b0, (b == 3), last, !last, link});
            end
            a = a + 64'd128;
        end
    endtask

    task automatic send_blk(input logic [63:0] addr, input logic [PW-1:0] link);
        bit   took = 0;
        int   n = 0;
        logic rdy;
        push_blk(addr, link);
        bus.iBLK_VALID = 1'b1;
        bus.iBLK_ADDR  = addr;
        bus.iBLK_LINK  = link;
        while (!took && n < 400) begin
            rdy = bus.oBLK_READY;
            step();
            if (rdy) took = 1;
            n++;
        end
        if (!took) chk("accept_timeout", 256'(0), 256'(1));
        bus.iBLK_VALID = 1'b0;
    endtask

    task automatic finish_blk(input string tag);
        int n = 0;
        while (sbq.size() != 0 && n < 400) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, 256'(sbq.size() == 0), 256'(1));
        chk({tag, "_done_ready"}, 256'(bus.oBLK_READY), 256'(0));
        chk({tag, "_done_valid"}, 256'(bus.oTX_ST.valid), 256'(0));
        step();
        chk({tag, "_idle_ready"}, 256'(bus.oBLK_READY), 256'(1));
        chk({tag, "_idle_req"}, 256'(bus.oREQ), 256'(0));
    endtask

    initial begin
        bit bad;
        int n;
        bus.iBLK_VALID = 1'b0;
        bus.iBLK_ADDR  = '0;
        bus.iBLK_LINK  = '0;
        bus.iGNT       = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req",   256'(bus.oREQ), 256'(0));
        chk("rst_valid", 256'(bus.oTX_ST.valid), 256'(0));
        chk("rst_done",  256'(bus.oBLK_DONE_PULSE), 256'(0));
        chk("rst_rd",    256'(bus.oDATA_RD), 256'(0));
        chk("rst_blkcnt", 256'(blk_cnt), 256'(0));
        chk("rst_waitcnt", 256'(wait_cnt), 256'(0));
        rst = 1'b0;
        step();
        chk("ready_after_rst", 256'(bus.oBLK_READY), 256'(1));

        // 3DW block, immediate grant
        bus.iGNT = 1'b1;
        send_blk(64'h0000_0000_1000_0000, 4'd5);
        finish_blk("t1");

        // 4DW block, then a block whose address crosses 4 GB mid-way (low bits ignored)
        send_blk(64'h0000_0001_FFFF_F000, 4'd3);
        finish_blk("t2");
        send_blk(64'h0000_0000_FFFF_F87F, 4'd7);
        finish_blk("t2b");

        // Grant held off for 20 cycles
        bus.iGNT = 1'b0;
        send_blk(64'h0000_0000_2000_0000, 4'd9);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.oTX_ST.valid || !bus.oREQ) bad = 1;
            step();
        end
        chk("no_beat_before_grant", 256'(bad), 256'(0));
        bus.iGNT = 1'b1;
        chk("still_idle_at_grant", 256'(bus.oTX_ST.valid), 256'(0));
        step();
        chk("beat_after_grant", 256'(bus.oTX_ST.valid), 256'(1));
        finish_blk("t3");
`ifdef TX_DMA_MWR_STATS_EN
        chk("wait_cnt_20", 256'(wait_cnt), 256'(20));
        chk("blk_cnt_4", 256'(blk_cnt), 256'(4));
`else
        chk("wait_cnt_off", 256'(wait_cnt), 256'(0));
        chk("blk_cnt_off", 256'(blk_cnt), 256'(0));
`endif

        // Reset in the middle of a block
        beat_cnt = 0;
        send_blk(64'h0000_0000_3000_0000, 4'd2);
        n = 0;
        while (beat_cnt < 77 && n < 300) begin
            step();
            n++;
        end
        chk("beat77_reached", 256'(beat_cnt >= 77), 256'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_req",   256'(bus.oREQ), 256'(0));
        chk("mid_rst_valid", 256'(bus.oTX_ST.valid), 256'(0));
        chk("mid_rst_sop_eop", 256'({bus.oTX_ST.sop, bus.oTX_ST.eop}), 256'(0));
        chk("mid_rst_done",  256'(bus.oBLK_DONE_PULSE), 256'(0));
        chk("mid_rst_rd",    256'(bus.oDATA_RD), 256'(0));
        chk("mid_rst_data",  bus.oTX_ST_DATA, 256'(0));
        chk("mid_rst_cnts",  256'({blk_cnt, wait_cnt}), 256'(0));
        sbq.delete();
        exp_raddr = '0;
        rd_cnt    = 0;
        gap_pend  = 0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("ready_after_mid_rst", 256'(bus.oBLK_READY), 256'(1));

        // Back-to-back descriptors
        send_blk(64'h0000_0000_4000_0000, 4'd10);
        send_blk(64'h0000_0002_0000_0000, 4'd11);
        finish_blk("t5");
`ifdef TX_DMA_MWR_STATS_EN
        chk("blk_cnt_2", 256'(blk_cnt), 256'(2));
        chk("wait_cnt_0", 256'(wait_cnt), 256'(0));
`else
        chk("blk_cnt_off2", 256'(blk_cnt), 256'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
